fetch_pipeline_ctrl: RTL and testbench

Front-end state holder and consumer of the hazard unit's stall/flush controls. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register. It applies `pc_write`, `IF_ID_write`, `IF_flush`, `ID_flush` and the branch redirect (`pc_src`) with a fixed priority. Optional performance counters track stall and flush cycles.

---
 rtl/fetch_pipeline_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_pipeline_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pipeline_ctrl.sv
// Front-end state holder: PC, IF/ID register and ID/EX control, driven by hazard-unit stall/flush controls.
// Optional stall/flush performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_pipeline_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CTRL_W   = 10,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              IF_ID_write,
    input  logic              IF_flush,
    input  logic              ID_flush,
    input  logic              pc_src,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       instr_in,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    output logic [31:0]       pc_out,
    output logic [31:0]       IF_ID_pc,
    output logic [31:0]       IF_ID_instr,
    output logic              IF_ID_valid,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              stall;
    logic              redirect;
    logic [31:0]       pc_reg;
    logic [31:0]       pc_next;
    logic [31:0]       if_id_pc_reg;
    logic [31:0]       if_id_instr_reg;
    logic              if_id_valid_reg;
    logic [CTRL_W-1:0] id_ex_ctrl_reg;

    // A stall from either enable freezes the whole front end and blocks redirect/flush.
    assign stall    = !pc_write || !IF_ID_write;
    assign redirect = pc_src && !stall;

    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (stall) begin
            pc_next = pc_reg;
        end else if (redirect) begin
            pc_next = {branch_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= PC_RESET;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc_reg    <= 32'h0;
            if_id_instr_reg <= 32'h0;
            if_id_valid_reg <= 1'b0;
        end else if (!stall) begin
            if_id_pc_reg    <= pc_reg;
            if_id_instr_reg <= IF_flush ? 32'h0 : instr_in;
            if_id_valid_reg <= !IF_flush;
        end
    end

    // The bubble must go in even while stalled: that is how a load-use hazard is resolved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_ctrl_reg <= '0;
        end else begin
            id_ex_ctrl_reg <= ID_flush ? '0 : id_ctrl_in;
        end
    end

    assign pc_out      = pc_reg;
    assign IF_ID_pc    = if_id_pc_reg;
    assign IF_ID_instr = if_id_instr_reg;
    assign IF_ID_valid = if_id_valid_reg;
    assign ID_EX_ctrl  = id_ex_ctrl_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = stall;
    assign cnt_inc[1] = IF_flush && !stall;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            // Saturating: hold at all-ones rather than wrapping.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Directed self-checking bench for fetch_pipeline_ctrl (PC_RESET=0x100, CTRL_W=10, CNT_W=4).
module tb_fetch_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        IF_ID_write = 1'b1;
    logic        IF_flush = 1'b0;
    logic        ID_flush = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] instr_in = 32'h0;
    logic [9:0]  id_ctrl_in = 10'h0;
    logic [31:0] pc_out;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic [9:0]  ID_EX_ctrl;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;

    int errors = 0;
    int checks = 0;

    fetch_pipeline_ctrl #(
        .PC_RESET(32'h0000_0100),
        .CTRL_W  (10),
        .CNT_W   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (pc_write),
        .IF_ID_write  (IF_ID_write),
        .IF_flush     (IF_flush),
        .ID_flush     (ID_flush),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .instr_in     (instr_in),
        .id_ctrl_in   (id_ctrl_in),
        .pc_out       (pc_out),
        .IF_ID_pc     (IF_ID_pc),
        .IF_ID_instr  (IF_ID_instr),
        .IF_ID_valid  (IF_ID_valid),
        .ID_EX_ctrl   (ID_EX_ctrl),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h ifid=(%h,%h,%b) ctrl=%h scnt=%0d fcnt=%0d",
                 $time, pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid, ID_EX_ctrl, stall_cnt, flush_cnt);
    endtask

    task automatic idle_inputs();
        pc_write = 1'b1; IF_ID_write = 1'b1; IF_flush = 1'b0; ID_flush = 1'b0; pc_src = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if (pc_out !== 32'h100) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h100);
        end
        checks++;
        if ({IF_ID_pc, IF_ID_instr, IF_ID_valid} !== {32'h0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL reset_ifid: got (%h,%h,%b) expected (0,0,0)", IF_ID_pc, IF_ID_instr, IF_ID_valid);
        end
        checks++;
        if ({ID_EX_ctrl, stall_cnt, flush_cnt} !== 18'h0) begin
            errors++; $display("FAIL reset_ctrl_cnt: got ctrl=%h s=%0d f=%0d expected 0", ID_EX_ctrl, stall_cnt, flush_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [31:0] instrs [3];
        instrs[0] = 32'hAAAA_0001; instrs[1] = 32'hBBBB_0002; instrs[2] = 32'hCCCC_0003;
        id_ctrl_in = 10'h155;
        for (int i = 0; i < 3; i++) begin
            instr_in = instrs[i];
            step();
            checks++;
            if (pc_out !== 32'h100 + 32'(4 * (i + 1))) begin
                errors++; $display("FAIL free_run_pc[%0d]: got %h expected %h", i, pc_out, 32'h100 + 32'(4 * (i + 1)));
            end
            checks++;
            if ({IF_ID_pc, IF_ID_instr, IF_ID_valid} !== {32'h100 + 32'(4 * i), instrs[i], 1'b1}) begin
                errors++; $display("FAIL free_run_ifid[%0d]: got (%h,%h,%b) expected (%h,%h,1)", i,
                                   IF_ID_pc, IF_ID_instr, IF_ID_valid, 32'h100 + 32'(4 * i), instrs[i]);
            end
        end
        checks++;
        if (ID_EX_ctrl !== 10'h155) begin
            errors++; $display("FAIL free_run_ctrl: got %h expected %h", ID_EX_ctrl, 10'h155);
        end
    endtask

    task automatic test_load_use_stall();
        pc_write = 1'b0; IF_ID_write = 1'b0; ID_flush = 1'b1;
        id_ctrl_in = 10'h3FF; instr_in = 32'hDEAD_BEEF;
        step();
        checks++;
        if (pc_out !== 32'h10C) begin
            errors++; $display("FAIL stall_pc: got %h expected %h", pc_out, 32'h10C);
        end
        checks++;
        if ({IF_ID_pc, IF_ID_instr, IF_ID_valid} !== {32'h108, 32'hCCCC_0003, 1'b1}) begin
            errors++; $display("FAIL stall_ifid: got (%h,%h,%b) expected (108,cccc0003,1)", IF_ID_pc, IF_ID_instr, IF_ID_valid);
        end
        checks++;
        if (ID_EX_ctrl !== 10'h0) begin
            errors++; $display("FAIL stall_bubble: got %h expected 0", ID_EX_ctrl);
        end
        idle_inputs();
        id_ctrl_in = 10'h2AA; instr_in = 32'hDDDD_0004;
        step();
        checks++;
        if ({pc_out, IF_ID_pc, IF_ID_instr, ID_EX_ctrl} !== {32'h110, 32'h10C, 32'hDDDD_0004, 10'h2AA}) begin
            errors++; $display("FAIL stall_resume: got pc=%h ifid=(%h,%h) ctrl=%h expected pc=110 ifid=(10c,dddd0004) ctrl=2aa",
                               pc_out, IF_ID_pc, IF_ID_instr, ID_EX_ctrl);
        end
    endtask

    task automatic test_branch();
        pc_src = 1'b1; IF_flush = 1'b1; ID_flush = 1'b1;
        branch_target = 32'h0000_0043; instr_in = 32'hEEEE_0005;
        step();
        checks++;
        if (pc_out !== 32'h40) begin
            errors++; $display("FAIL branch_pc_align: got %h expected %h", pc_out, 32'h40);
        end
        checks++;
        if ({IF_ID_pc, IF_ID_instr, IF_ID_valid, ID_EX_ctrl} !== {32'h110, 32'h0, 1'b0, 10'h0}) begin
            errors++; $display("FAIL branch_flush: got ifid=(%h,%h,%b) ctrl=%h expected (110,0,0) ctrl=0",
                               IF_ID_pc, IF_ID_instr, IF_ID_valid, ID_EX_ctrl);
        end
        idle_inputs();
        instr_in = 32'hFFFF_0006;
        step();
        checks++;
        if ({pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid} !== {32'h44, 32'h40, 32'hFFFF_0006, 1'b1}) begin
            errors++; $display("FAIL branch_target_fetch: got pc=%h ifid=(%h,%h,%b) expected pc=44 ifid=(40,ffff0006,1)",
                               pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid);
        end
    endtask

    task automatic test_stall_branch();
        pc_write = 1'b0; pc_src = 1'b1; IF_flush = 1'b1; ID_flush = 1'b1;
        branch_target = 32'h200; instr_in = 32'h1234_5678;
        step();
        checks++;
        if ({pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid} !== {32'h44, 32'h40, 32'hFFFF_0006, 1'b1}) begin
            errors++; $display("FAIL stall_branch_hold: got pc=%h ifid=(%h,%h,%b) expected pc=44 ifid=(40,ffff0006,1)",
                               pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid);
        end
        checks++;
        if (ID_EX_ctrl !== 10'h0) begin
            errors++; $display("FAIL stall_branch_bubble: got %h expected 0", ID_EX_ctrl);
        end
        pc_write = 1'b1; ID_flush = 1'b0;
        step();
        checks++;
        if ({pc_out, IF_ID_pc, IF_ID_valid, ID_EX_ctrl} !== {32'h200, 32'h44, 1'b0, 10'h2AA}) begin
            errors++; $display("FAIL stall_branch_retry: got pc=%h ifid_pc=%h v=%b ctrl=%h expected pc=200 ifid_pc=44 v=0 ctrl=2aa",
                               pc_out, IF_ID_pc, IF_ID_valid, ID_EX_ctrl);
        end
    endtask

    task automatic test_wrap();
        pc_src = 1'b1; IF_flush = 1'b0; branch_target = 32'hFFFF_FFFF; instr_in = 32'h0BAD_0007;
        step();
        checks++;
        if ({pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid} !== {32'hFFFF_FFFC, 32'h200, 32'h0BAD_0007, 1'b1}) begin
            errors++; $display("FAIL wrap_target: got pc=%h ifid=(%h,%h,%b) expected pc=fffffffc ifid=(200,0bad0007,1)",
                               pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid);
        end
        idle_inputs();
        step();
        checks++;
        if (pc_out !== 32'h0) begin
            errors++; $display("FAIL wrap_pc: got %h expected 0", pc_out);
        end
        IF_ID_write = 1'b0;
        step();
        checks++;
        if ({pc_out, IF_ID_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL ifid_write_stall: got pc=%h ifid_pc=%h expected pc=0 ifid_pc=fffffffc", pc_out, IF_ID_pc);
        end
        IF_ID_write = 1'b1;
    endtask

    task automatic test_counters();
        logic [3:0] exp_stall;
        logic [3:0] exp_flush;
`ifdef FETCH_PERF_CNT_EN
        exp_stall = 4'd3; exp_flush = 4'd2;
`else
        exp_stall = 4'd0; exp_flush = 4'd0;
`endif
        checks++;
        if ({stall_cnt, flush_cnt} !== {exp_stall, exp_flush}) begin
            errors++; $display("FAIL counters_mid: got s=%0d f=%0d expected s=%0d f=%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
        pc_write = 1'b0;
        repeat (20) step();
`ifdef FETCH_PERF_CNT_EN
        exp_stall = 4'd15;
`endif
        checks++;
        if ({stall_cnt, flush_cnt, pc_out} !== {exp_stall, exp_flush, 32'h0}) begin
            errors++; $display("FAIL counters_sat: got s=%0d f=%0d pc=%h expected s=%0d f=%0d pc=0",
                               stall_cnt, flush_cnt, pc_out, exp_stall, exp_flush);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        step();
        #2 rst = 1'b1;
        #1;
        $display("t=%0t async reset pc=%h v=%b", $time, pc_out, IF_ID_valid);
        checks++;
        if ({pc_out, IF_ID_pc, IF_ID_valid, ID_EX_ctrl, stall_cnt} !== {32'h100, 32'h0, 1'b0, 10'h0, 4'h0}) begin
            errors++; $display("FAIL async_reset: got pc=%h ifid_pc=%h v=%b ctrl=%h s=%0d expected pc=100 rest 0",
                               pc_out, IF_ID_pc, IF_ID_valid, ID_EX_ctrl, stall_cnt);
        end
        step();
        rst = 1'b0;
        instr_in = 32'h5555_0008;
        step();
        checks++;
        if ({pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid} !== {32'h104, 32'h100, 32'h5555_0008, 1'b1}) begin
            errors++; $display("FAIL post_reset_fetch: got pc=%h ifid=(%h,%h,%b) expected pc=104 ifid=(100,55550008,1)",
                               pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_load_use_stall();
        test_branch();
        test_stall_branch();
        test_wrap();
        test_counters();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
